// File: rtl/cache2w_ctrl.sv
// Lookup/refill controller for a 2-way set-associative read cache: tag/valid/LRU
// state, one-hot way-hit select, data-bank write control and 4-beat line refill.
module cache2w_ctrl #(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 32 - INDEX_W - 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_valid,
    input  logic [31:0]        cpu_addr,
    output logic               cpu_req_ready,
    input  logic               cache_flush,
    output logic [1:0]         hit,
    output logic               rdata_valid,
    output logic [INDEX_W-1:0] data_index,
    output logic [1:0]         data_we,
    output logic [127:0]       refill_data,
    output logic               mem_rd_req,
    output logic [31:0]        mem_rd_addr,
    input  logic               mem_rd_ready,
    input  logic               mem_ret_valid,
    input  logic [31:0]        mem_ret_data
);

    localparam int SETS = 1 << INDEX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_FILL     = 3'd4;

    logic [2:0]         state_reg, state_next;
    logic [TAG_W-1:0]   tag_reg;
    logic [INDEX_W-1:0] idx_reg;
    logic               victim_reg;
    logic [1:0]         beat_reg;
    logic [127:0]       refill_reg;
    logic [SETS-1:0]    lru_reg;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [1:0]         way_hit;
    logic [1:0]         way_valid;
    logic               in_lookup;
    logic               lookup_hit;
    logic               accept;
    logic               flush_now;
    logic               in_fill;
    logic               victim_sel;
    logic               unused_offset;

    assign addr_tag      = cpu_addr[31:INDEX_W+4];
    assign addr_idx      = cpu_addr[INDEX_W+3:4];
    assign unused_offset = ^cpu_addr[3:0];

    assign in_lookup  = (state_reg == S_LOOKUP);
    assign in_fill    = (state_reg == S_FILL);
    assign lookup_hit = in_lookup & (|way_hit);
    assign flush_now  = (state_reg == S_IDLE) & cache_flush;

    // Gated by rst so every output reads 0 while reset is held.
    assign cpu_req_ready = ~rst & (((state_reg == S_IDLE) & ~cache_flush) | lookup_hit);
    assign accept        = cpu_req_valid & cpu_req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [TAG_W-1:0] tag_mem [SETS];
            logic [SETS-1:0]  valid_reg;

            always_ff @(posedge clk) begin
                if (data_we[gi]) begin
                    tag_mem[idx_reg] <= tag_reg;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (flush_now) begin
                    valid_reg <= '0;
                end else if (data_we[gi]) begin
                    valid_reg[idx_reg] <= 1'b1;
                end
            end

            assign way_valid[gi] = valid_reg[idx_reg];
            assign way_hit[gi]   = valid_reg[idx_reg] & (tag_mem[idx_reg] == tag_reg);
            assign data_we[gi]   = in_fill & (victim_reg == 1'(gi));
        end
    endgenerate

    // Fill an empty way before evicting; otherwise the LRU bit names the victim.
    assign victim_sel = ~way_valid[0] ? 1'b0 :
                        ~way_valid[1] ? 1'b1 : lru_reg[idx_reg];

    assign hit         = in_lookup ? way_hit : 2'b00;
    assign rdata_valid = lookup_hit;
    assign data_index  = accept ? addr_idx : idx_reg;
    assign mem_rd_req  = (state_reg == S_MISS_REQ);
    assign mem_rd_addr = {tag_reg, idx_reg, 4'b0000};
    assign refill_data = refill_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit) state_next = accept ? S_LOOKUP : S_IDLE;
                else            state_next = S_MISS_REQ;
            end
            S_MISS_REQ: begin
                if (mem_rd_ready) state_next = S_REFILL;
            end
            S_REFILL: begin
                if (mem_ret_valid && beat_reg == 2'd3) state_next = S_FILL;
            end
            S_FILL: begin
                state_next = S_LOOKUP;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            tag_reg    <= '0;
            idx_reg    <= '0;
            victim_reg <= 1'b0;
            beat_reg   <= 2'd0;
            refill_reg <= '0;
            lru_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                tag_reg <= addr_tag;
                idx_reg <= addr_idx;
            end
            if (in_lookup && !lookup_hit) begin
                victim_reg <= victim_sel;
            end
            if (state_reg == S_MISS_REQ) begin
                beat_reg <= 2'd0;
            end else if (state_reg == S_REFILL && mem_ret_valid) begin
                refill_reg[{beat_reg, 5'd0} +: 32] <= mem_ret_data;
                beat_reg <= beat_reg + 2'd1;
            end
            // LRU bit holds the way to evict next: the one not just used.
            if (lookup_hit) begin
                lru_reg[idx_reg] <= way_hit[0];
            end else if (in_fill) begin
                lru_reg[idx_reg] <= ~victim_reg;
            end
        end
    end

endmodule
